carry_look_ahead_adder: RTL and testbench

- Parameterised two-level carry look-ahead adder: sum_o/carry_o = a_i + b_i + carry_i.
- Bits are grouped into 4-bit look-ahead blocks. A second-level look-ahead unit computes the block carry-ins from the group generate/propagate signals.
- Sum and carry are registered once at the output, giving one-cycle latency. The block serves as an arithmetic leaf in datapaths and is the teaching example for the blog series.

---
 rtl/cla_pkg.sv | 16 +
 rtl/cla_block_4b.sv | 37 +++
 rtl/carry_look_ahead_adder.sv | 138 +++++++++++++
 tb/tb_carry_look_ahead_adder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
`default_nettype none
// =============================================================================
// Module      : cla_pkg
// Description : Shared constants and sizing helper for the carry look-ahead adder.
// Revision    : 1.0 - initial release
// =============================================================================
package cla_pkg;

   localparam int CLA_BLOCK_WIDTH = 4;

   function automatic int cla_num_blocks(input int width);
      return (width + CLA_BLOCK_WIDTH - 1) / CLA_BLOCK_WIDTH;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cla_block_4b.sv
`default_nettype none
// =============================================================================
// Module      : cla_block_4b
// Description : 4-bit look-ahead block: expanded carries, sum, group G/P.
// Revision    : 1.0 - initial release
// =============================================================================
module cla_block_4b (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       gg,
   output logic       gp
);

   logic [3:0] w_g;
   logic [3:0] w_p;
   logic [3:0] w_c;

   assign w_g = a & b;
   assign w_p = a ^ b;

   // Every carry is a flat sum of products of g/p and cin; no carry feeds another.
   assign w_c[0] = cin;
   assign w_c[1] = w_g[0] | (w_p[0] & cin);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & cin);

   assign gg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
   assign gp = &w_p;

   assign sum = w_p ^ w_c;

endmodule
`default_nettype wire

// File: rtl/carry_look_ahead_adder.sv
`default_nettype none
// =============================================================================
// Module      : carry_look_ahead_adder
// Description : Two-level registered CLA; {carry_o,sum_o} = a_i + b_i + carry_i.
//               Optional group_g_o/group_p_o outputs under CLA_GROUP_PG_OUT_EN.
// Revision    : 1.0 - initial release
// =============================================================================
module carry_look_ahead_adder
   import cla_pkg::*;
#(
   parameter int CLA_WIDTH = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [CLA_WIDTH-1:0] a_i,
   input  logic [CLA_WIDTH-1:0] b_i,
   input  logic                 carry_i,
   output logic [CLA_WIDTH-1:0] sum_o,
   output logic                 carry_o
`ifdef CLA_GROUP_PG_OUT_EN
   ,
   output logic                 group_g_o,
   output logic                 group_p_o
`endif
);

   localparam int NBLK  = cla_num_blocks(CLA_WIDTH);
   localparam int PAD_W = NBLK * CLA_BLOCK_WIDTH;

   logic [PAD_W-1:0]     w_a_pad;
   logic [PAD_W-1:0]     w_b_pad;
   logic [PAD_W-1:0]     w_sum_pad;
   logic [NBLK-1:0]      w_gg;
   logic [NBLK-1:0]      w_gp;
   logic [NBLK:0]        w_blk_cin;
   logic                 w_carry;
   logic [CLA_WIDTH-1:0] r_sum;
   logic                 r_carry;

   assign w_a_pad = PAD_W'(a_i);
   assign w_b_pad = PAD_W'(b_i);

   for (genvar k = 0; k < NBLK; k++) begin : g_blk
      cla_block_4b u_blk (
         .a   (w_a_pad[k*CLA_BLOCK_WIDTH +: CLA_BLOCK_WIDTH]),
         .b   (w_b_pad[k*CLA_BLOCK_WIDTH +: CLA_BLOCK_WIDTH]),
         .cin (w_blk_cin[k]),
         .sum (w_sum_pad[k*CLA_BLOCK_WIDTH +: CLA_BLOCK_WIDTH]),
         .gg  (w_gg[k]),
         .gp  (w_gp[k])
      );
   end

   // Second level: each block carry-in is a flat OR of GG[j]·GP[j+1..k-1] terms
   // plus the GP[0..k-1]·carry_i term, so no block waits on its neighbour.
   always_comb begin : p_lookahead
      logic v_term;
      v_term       = 1'b0;
      w_blk_cin    = '0;
      w_blk_cin[0] = carry_i;
      for (int k = 1; k <= NBLK; k++) begin
         for (int j = 0; j < k; j++) begin
            v_term = w_gg[j];
            for (int m = j + 1; m < k; m++) begin
               v_term = v_term & w_gp[m];
            end
            w_blk_cin[k] = w_blk_cin[k] | v_term;
         end
         v_term = carry_i;
         for (int m = 0; m < k; m++) begin
            v_term = v_term & w_gp[m];
         end
         w_blk_cin[k] = w_blk_cin[k] | v_term;
      end
   end

   // With padding, the carry into bit CLA_WIDTH lands as the sum of a zero bit.
   if (PAD_W == CLA_WIDTH) begin : g_carry_exact
      assign w_carry = w_blk_cin[NBLK];
   end else begin : g_carry_pad
      assign w_carry = w_sum_pad[CLA_WIDTH];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_sum   <= '0;
         r_carry <= 1'b0;
      end else begin
         r_sum   <= w_sum_pad[CLA_WIDTH-1:0];
         r_carry <= w_carry;
      end
   end

   assign sum_o   = r_sum;
   assign carry_o = r_carry;

`ifdef CLA_GROUP_PG_OUT_EN
   logic [CLA_WIDTH-1:0] w_g_bit;
   logic [CLA_WIDTH-1:0] w_p_bit;
   logic                 w_group_g;
   logic                 w_group_p;
   logic                 r_group_g;
   logic                 r_group_p;

   assign w_g_bit   = a_i & b_i;
   assign w_p_bit   = a_i ^ b_i;
   assign w_group_p = &w_p_bit;

   // Group generate over the true width only, so padding cannot mask it.
   always_comb begin : p_group_g
      logic v_term;
      v_term    = 1'b0;
      w_group_g = 1'b0;
      for (int i = 0; i < CLA_WIDTH; i++) begin
         v_term = w_g_bit[i];
         for (int m = i + 1; m < CLA_WIDTH; m++) begin
            v_term = v_term & w_p_bit[m];
         end
         w_group_g = w_group_g | v_term;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_group_g <= 1'b0;
         r_group_p <= 1'b0;
      end else begin
         r_group_g <= w_group_g;
         r_group_p <= w_group_p;
      end
   end

   assign group_g_o = r_group_g;
   assign group_p_o = r_group_p;
`endif

endmodule
`default_nettype wire

// File: tb/tb_carry_look_ahead_adder.sv
`default_nettype none
// =============================================================================
// Module      : tb_carry_look_ahead_adder
// Description : Self-checking bench for the 8-bit and 6-bit adder configurations.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_carry_look_ahead_adder;

   logic       clk;
   logic       rst_n;
   logic [7:0] a8;
   logic [7:0] b8;
   logic       cin8;
   logic [7:0] sum8;
   logic       cout8;
   logic [5:0] a6;
   logic [5:0] b6;
   logic       cin6;
   logic [5:0] sum6;
   logic       cout6;
`ifdef CLA_GROUP_PG_OUT_EN
   logic       gg8;
   logic       gp8;
   logic       gg6;
   logic       gp6;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   carry_look_ahead_adder #(.CLA_WIDTH(8)) u_dut8 (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .a_i       (a8),
      .b_i       (b8),
      .carry_i   (cin8),
      .sum_o     (sum8),
      .carry_o   (cout8)
`ifdef CLA_GROUP_PG_OUT_EN
      ,
      .group_g_o (gg8),
      .group_p_o (gp8)
`endif
   );

   carry_look_ahead_adder #(.CLA_WIDTH(6)) u_dut6 (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .a_i       (a6),
      .b_i       (b6),
      .carry_i   (cin6),
      .sum_o     (sum6),
      .carry_o   (cout6)
`ifdef CLA_GROUP_PG_OUT_EN
      ,
      .group_g_o (gg6),
      .group_p_o (gp6)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Reference: the exact (W+1)-bit integer sum.
   function automatic logic [63:0] ref_add(input logic [63:0] a, input logic [63:0] b,
                                           input logic cin);
      return a + b + 64'(cin);
   endfunction

   task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c);
      a8 = a; b8 = b; cin8 = c;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      drive8(8'hFF, 8'hFF, 1'b0);
      a6 = 6'h00; b6 = 6'h00; cin6 = 1'b0;
      #2;
      check_value("reset_sum", 64'(sum8), 64'h00);
      check_value("reset_carry", 64'(cout8), 64'h0);
      #1 rst_n = 1'b1;
      tick();
      check_value("post_reset", 64'({cout8, sum8}), 64'h1FE);

      drive8(8'h3C, 8'h05, 1'b1);
      tick();
      check_value("basic_add", 64'({cout8, sum8}), 64'h042);

      drive8(8'hFF, 8'h00, 1'b1);
      tick();
      check_value("chain_ff_00", 64'({cout8, sum8}), 64'h100);

      drive8(8'h0F, 8'hF0, 1'b1);
      tick();
      check_value("chain_blk_boundary", 64'({cout8, sum8}), 64'h100);

      drive8(8'hFF, 8'hFF, 1'b1);
      tick();
      check_value("max_max_1", 64'({cout8, sum8}), 64'h1FF);

      drive8(8'hFF, 8'h01, 1'b0);
      tick();
      check_value("wrap", 64'({cout8, sum8}), 64'h100);

      drive8(8'h00, 8'h00, 1'b0);
      tick();
      check_value("zero", 64'({cout8, sum8}), 64'h000);

      a6 = 6'h3F; b6 = 6'h01; cin6 = 1'b0;
      tick();
      check_value("w6_pad_carry", 64'({cout6, sum6}), 64'h40);

`ifdef CLA_GROUP_PG_OUT_EN
      drive8(8'hF0, 8'h0F, 1'b0);
      tick();
      check_value("group_p", 64'(gp8), 64'h1);
      check_value("group_g", 64'(gg8), 64'h0);
`endif

      // Mid-stream reset: output clears at once and the in-flight result is lost.
      drive8(8'hA5, 8'h5A, 1'b1);
      tick();
      check_value("pre_midreset", 64'({cout8, sum8}), 64'h100);
      drive8(8'h12, 8'h34, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check_value("midreset_async", 64'({cout8, sum8}), 64'h000);
      tick();
      check_value("midreset_held", 64'({cout8, sum8}), 64'h000);
      rst_n = 1'b1;
      tick();
      check_value("after_midreset", 64'({cout8, sum8}), 64'h046);

      // Back-to-back random vectors, one per cycle on both widths.
      for (int i = 0; i < 50; i++) begin
         logic [7:0]  ra;
         logic [7:0]  rb;
         logic        rc;
         logic [5:0]  sa;
         logic [5:0]  sb;
         logic        sc;
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         sa = 6'($urandom); sb = 6'($urandom); sc = 1'($urandom);
         drive8(ra, rb, rc);
         a6 = sa; b6 = sb; cin6 = sc;
         tick();
         check_value("rand8", 64'({cout8, sum8}), ref_add(64'(ra), 64'(rb), rc));
         check_value("rand6", 64'({cout6, sum6}), ref_add(64'(sa), 64'(sb), sc));
`ifdef CLA_GROUP_PG_OUT_EN
         check_value("rand8_gp", 64'(gp8), 64'((ra ^ rb) == 8'hFF));
         check_value("rand8_gg", 64'(gg8), ref_add(64'(ra), 64'(rb), 1'b0) >> 8);
         check_value("rand6_gg", 64'(gg6), ref_add(64'(sa), 64'(sb), 1'b0) >> 6);
`endif
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
